// File: rtl/emin_engine_if.sv
// Handshake and memory bus bundle for emin_engine: start request, T BRAM read port,
// and result stream. The slave modport is the engine side.
interface emin_engine_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IW    = 8
);
  logic                      start_valid_in;
  logic                      start_ready_out;
  logic [IW-1:0]             i_in;
  logic [IW-1:0]             j_lo_in;
  logic                      mode_in;
  logic                      t_rd_out;
  logic [IW-1:0]             t_addr_out;
  logic [3*WIDTH-1:0]        t_data_in;
  logic                      out_valid_out;
  logic                      out_ready_in;
  logic [IW-1:0]             j_out;
  logic signed [WIDTH-1:0]   data_out;
  logic                      degenerate_out;
  logic                      last_out;
  logic                      range_err_out;
  logic                      busy_out;

  modport slave (
    input  start_valid_in, i_in, j_lo_in, mode_in, t_data_in, out_ready_in,
    output start_ready_out, t_rd_out, t_addr_out, out_valid_out, j_out,
           data_out, degenerate_out, last_out, range_err_out, busy_out
  );

  modport master (
    output start_valid_in, i_in, j_lo_in, mode_in, t_data_in, out_ready_in,
    input  start_ready_out, t_rd_out, t_addr_out, out_valid_out, j_out,
           data_out, degenerate_out, last_out, range_err_out, busy_out
  );
endinterface

// File: rtl/emin_engine.sv
// Minimum segment energy E_min(j, i) over j in [j_lo, i] from a three-channel
// prefix-sum table, with fixed-latency bit-serial division of the fit coefficients.
module emin_engine #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FRAC        = 16,
  parameter int unsigned I_MAX       = 160,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  emin_engine_if.slave bus
);

  localparam int unsigned IW      = $clog2(I_MAX);
  localparam int unsigned W2      = 2 * WIDTH;
  localparam int unsigned QW      = WIDTH + FRAC;
  localparam int unsigned DIV_CYC = WIDTH + FRAC;
  localparam int unsigned CW      = $clog2(DIV_CYC + MEM_LATENCY + 2);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FI_LAST  = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] FJ_LAST  = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYC - 1);
  localparam logic [IW-1:0] J_ONE    = IW'(1);
  localparam logic [IW:0]   I_LIMIT  = (IW + 1)'(I_MAX);

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_I, S_FETCH_J, S_RDIFF, S_PROD, S_DIV, S_COMB, S_OUT
  } state_t;

  // Saturating signed subtraction a - b.
  function automatic logic signed [WIDTH-1:0] f_sat_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] diff;
    diff = (WIDTH + 1)'(a) - (WIDTH + 1)'(b);
    if (diff[WIDTH] != diff[WIDTH-1]) return diff[WIDTH] ? S_MIN : S_MAX;
    return WIDTH'(diff);
  endfunction

  // Fixed-point multiply: full product, arithmetic shift by FRAC, saturate.
  function automatic logic signed [WIDTH-1:0] f_mulq(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [W2-1:0] prod;
    logic signed [W2-1:0] shr;
    prod = W2'(a) * W2'(b);
    shr  = prod >>> FRAC;
    if ((shr[W2-1:WIDTH-1] == '0) || (shr[W2-1:WIDTH-1] == '1)) return WIDTH'(shr);
    return shr[W2-1] ? S_MIN : S_MAX;
  endfunction

  function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] a);
    return a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
  endfunction

  // Apply sign to an unsigned quotient magnitude and saturate to WIDTH.
  function automatic logic signed [WIDTH-1:0] f_qsat(
    input logic [QW-1:0] q,
    input logic          neg
  );
    if (q[QW-1:WIDTH-1] != '0) return neg ? S_MIN : S_MAX;
    return neg ? -$signed(q[WIDTH-1:0]) : $signed(q[WIDTH-1:0]);
  endfunction

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_i;
  logic [IW-1:0]           r_j;
  logic                    r_mode;
  logic signed [WIDTH-1:0] r_ti0, r_ti1, r_ti2;
  logic signed [WIDTH-1:0] r_r0, r_r1, r_r2;
  logic                    r_sa, r_sb, r_degen;
  logic [WIDTH-1:0]        r_dmag;
  logic [WIDTH-1:0]        r_rem_a, r_rem_b;
  logic [QW-1:0]           r_aq_a, r_aq_b;

  logic                    r_start_ready;
  logic                    r_t_rd;
  logic [IW-1:0]           r_t_addr;
  logic                    r_out_valid;
  logic [IW-1:0]           r_j_out;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_degen_out;
  logic                    r_last;
  logic                    r_range_err;
  logic                    r_busy;

  logic signed [WIDTH-1:0] w_t0, w_t1, w_t2;
  logic signed [WIDTH-1:0] w_tj0, w_tj1, w_tj2;
  logic signed [WIDTH-1:0] w_an, w_bn, w_d;
  logic signed [WIDTH-1:0] w_alpha, w_beta, w_e;
  logic [WIDTH:0]          w_rsh_a, w_rsh_b;
  logic                    w_ge_a, w_ge_b;
  logic [WIDTH-1:0]        w_rem_a_nx, w_rem_b_nx;
  logic                    w_start_bad;

  assign w_t0 = $signed(bus.t_data_in[3*WIDTH-1:2*WIDTH]);
  assign w_t1 = $signed(bus.t_data_in[2*WIDTH-1:WIDTH]);
  assign w_t2 = $signed(bus.t_data_in[WIDTH-1:0]);

  // j == 0 has no preceding prefix entry; its T_j is defined as zero.
  assign w_tj0 = (r_j == '0) ? '0 : w_t0;
  assign w_tj1 = (r_j == '0) ? '0 : w_t1;
  assign w_tj2 = (r_j == '0) ? '0 : w_t2;

  assign w_start_bad = ({1'b0, bus.i_in} >= I_LIMIT) || (bus.j_lo_in > bus.i_in);

  // Fit numerators and denominator for the selected mode.
  always_comb begin
    w_an = r_r1;
    w_bn = '0;
    w_d  = r_r0;
    if (!r_mode) begin
      w_an = f_sat_sub(f_mulq(r_r0, r_r1), f_mulq(r_r1, r_r2));
      w_bn = f_sat_sub(f_mulq(r_r0, r_r2), f_mulq(r_r1, r_r1));
      w_d  = f_sat_sub(f_mulq(r_r0, r_r0), f_mulq(r_r1, r_r1));
    end
  end

  // One restoring-division step for each of the two quotients.
  assign w_rsh_a    = {r_rem_a, r_aq_a[QW-1]};
  assign w_rsh_b    = {r_rem_b, r_aq_b[QW-1]};
  assign w_ge_a     = (w_rsh_a >= {1'b0, r_dmag});
  assign w_ge_b     = (w_rsh_b >= {1'b0, r_dmag});
  assign w_rem_a_nx = w_ge_a ? WIDTH'(w_rsh_a - {1'b0, r_dmag}) : WIDTH'(w_rsh_a);
  assign w_rem_b_nx = w_ge_b ? WIDTH'(w_rsh_b - {1'b0, r_dmag}) : WIDTH'(w_rsh_b);

  assign w_alpha = r_degen ? '0 : f_qsat(r_aq_a, r_sa);
  assign w_beta  = r_degen ? '0 : f_qsat(r_aq_b, r_sb);
  assign w_e     = f_sat_sub(f_sat_sub(r_r0, f_mulq(r_r1, w_alpha)), f_mulq(r_r2, w_beta));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_mode        <= 1'b0;
      r_ti0         <= '0;
      r_ti1         <= '0;
      r_ti2         <= '0;
      r_r0          <= '0;
      r_r1          <= '0;
      r_r2          <= '0;
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
      r_degen       <= 1'b0;
      r_dmag        <= '0;
      r_rem_a       <= '0;
      r_rem_b       <= '0;
      r_aq_a        <= '0;
      r_aq_b        <= '0;
      r_start_ready <= 1'b1;
      r_t_rd        <= 1'b0;
      r_t_addr      <= '0;
      r_out_valid   <= 1'b0;
      r_j_out       <= '0;
      r_data        <= '0;
      r_degen_out   <= 1'b0;
      r_last        <= 1'b0;
      r_range_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_t_rd      <= 1'b0;
      r_range_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid_in && r_start_ready) begin
            r_i    <= bus.i_in;
            r_j    <= bus.j_lo_in;
            r_mode <= bus.mode_in;
            if (w_start_bad) begin
              r_range_err <= 1'b1;
            end else begin
              r_t_rd        <= 1'b1;
              r_t_addr      <= bus.i_in;
              r_cnt         <= '0;
              r_start_ready <= 1'b0;
              r_busy        <= 1'b1;
              r_state       <= S_FETCH_I;
            end
          end
        end
        S_FETCH_I: begin
          if (r_cnt == FI_LAST) begin
            r_ti0   <= w_t0;
            r_ti1   <= w_t1;
            r_ti2   <= w_t2;
            r_cnt   <= '0;
            r_state <= S_FETCH_J;
            if (r_j != '0) begin
              r_t_rd   <= 1'b1;
              r_t_addr <= r_j - J_ONE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        // Same wait whether or not a read was issued, so per-j timing is fixed.
        S_FETCH_J: begin
          if (r_cnt == FJ_LAST) r_state <= S_RDIFF;
          else                  r_cnt   <= r_cnt + CNT_ONE;
        end
        S_RDIFF: begin
          r_r0    <= r_ti0 - w_tj0;
          r_r1    <= r_ti1 - w_tj1;
          r_r2    <= r_ti2 - w_tj2;
          r_state <= S_PROD;
        end
        S_PROD: begin
          r_sa    <= w_an[WIDTH-1] ^ w_d[WIDTH-1];
          r_sb    <= w_bn[WIDTH-1] ^ w_d[WIDTH-1];
          r_degen <= (w_d == '0);
          r_dmag  <= f_abs(w_d);
          r_aq_a  <= {f_abs(w_an), {FRAC{1'b0}}};
          r_aq_b  <= {f_abs(w_bn), {FRAC{1'b0}}};
          r_rem_a <= '0;
          r_rem_b <= '0;
          r_cnt   <= '0;
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_rem_a <= w_rem_a_nx;
          r_rem_b <= w_rem_b_nx;
          r_aq_a  <= {r_aq_a[QW-2:0], w_ge_a};
          r_aq_b  <= {r_aq_b[QW-2:0], w_ge_b};
          if (r_cnt == DIV_LAST) r_state <= S_COMB;
          else                   r_cnt   <= r_cnt + CNT_ONE;
        end
        S_COMB: begin
          r_data      <= w_e;
          r_j_out     <= r_j;
          r_degen_out <= r_degen;
          r_last      <= (r_j == r_i);
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready_in) begin
            r_out_valid <= 1'b0;
            if (r_last) begin
              r_start_ready <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_j      <= r_j + J_ONE;
              r_cnt    <= '0;
              r_t_rd   <= 1'b1;
              r_t_addr <= r_j;
              r_state  <= S_FETCH_J;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready_out = r_start_ready;
  assign bus.t_rd_out        = r_t_rd;
  assign bus.t_addr_out      = r_t_addr;
  assign bus.out_valid_out   = r_out_valid;
  assign bus.j_out           = r_j_out;
  assign bus.data_out        = r_data;
  assign bus.degenerate_out  = r_degen_out;
  assign bus.last_out        = r_last;
  assign bus.range_err_out   = r_range_err;
  assign bus.busy_out        = r_busy;

endmodule

// File: tb/tb_emin_engine.sv
// Scoreboard bench for emin_engine: a reference model pushes expected results at job
// start, a monitor pops and compares them on every output handshake.
module tb_emin_engine;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned I_MAX = 160;
  localparam int unsigned ML    = 2;
  localparam int unsigned IW    = $clog2(I_MAX);
  localparam longint      L_MAX = (longint'(1) <<< 31) - 1;
  localparam longint      L_MIN = -(longint'(1) <<< 31);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  emin_engine_if #(.WIDTH(WIDTH), .IW(IW)) bus ();

  emin_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .I_MAX(I_MAX), .MEM_LATENCY(ML)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // T table and a MEM_LATENCY-deep read pipeline; idle slots carry junk.
  logic signed [WIDTH-1:0] tab0 [I_MAX];
  logic signed [WIDTH-1:0] tab1 [I_MAX];
  logic signed [WIDTH-1:0] tab2 [I_MAX];
  logic [3*WIDTH-1:0]      pipe [ML];

  always @(posedge clk) begin
    pipe[0] <= bus.t_rd_out ? {tab0[bus.t_addr_out], tab1[bus.t_addr_out], tab2[bus.t_addr_out]}
                            : {3{32'hDEAD_BEEF}};
    for (int k = 1; k < int'(ML); k++) pipe[k] <= pipe[k-1];
  end
  assign bus.t_data_in = pipe[ML-1];

  typedef struct {
    longint j;
    longint data;
    longint degen;
    longint last;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic longint sat_w(input longint v);
    if (v > L_MAX) return L_MAX;
    if (v < L_MIN) return L_MIN;
    return v;
  endfunction

  function automatic longint mq(input longint a, input longint b);
    return sat_w((a * b) >>> FRAC);
  endfunction

  function automatic longint ssub(input longint a, input longint b);
    return sat_w(a - b);
  endfunction

  function automatic longint qdiv(input longint n, input longint d);
    longint na, nd, q;
    na = (n < 0) ? -n : n;
    nd = (d < 0) ? -d : d;
    q  = (na <<< FRAC) / nd;
    return ((n < 0) != (d < 0)) ? sat_w(-q) : sat_w(q);
  endfunction

  task automatic push_exp(input int j, input longint data, input int degen, input int last);
    exp_t e;
    e.j = j; e.data = data; e.degen = degen; e.last = last;
    sb.push_back(e);
  endtask

  // Reference model of one job for j in [jfrom, jto].
  task automatic push_model(input int i, input int jfrom, input int jto, input bit mode);
    logic signed [WIDTH-1:0] tj0, tj1, tj2, r0, r1, r2;
    longint a0, a1, a2, an, bn, d, al, be, e;
    for (int j = jfrom; j <= jto; j++) begin
      tj0 = (j == 0) ? '0 : tab0[j-1];
      tj1 = (j == 0) ? '0 : tab1[j-1];
      tj2 = (j == 0) ? '0 : tab2[j-1];
      r0 = tab0[i] - tj0;
      r1 = tab1[i] - tj1;
      r2 = tab2[i] - tj2;
      a0 = longint'(r0); a1 = longint'(r1); a2 = longint'(r2);
      if (mode) begin
        an = a1; bn = 0; d = a0;
      end else begin
        an = ssub(mq(a0, a1), mq(a1, a2));
        bn = ssub(mq(a0, a2), mq(a1, a1));
        d  = ssub(mq(a0, a0), mq(a1, a1));
      end
      al = (d == 0) ? 0 : qdiv(an, d);
      be = (d == 0) ? 0 : qdiv(bn, d);
      e  = ssub(ssub(a0, mq(a1, al)), mq(a2, be));
      push_exp(j, e, (d == 0) ? 1 : 0, (j == i) ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid_out && bus.out_ready_in) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("j_out", longint'(bus.j_out), mon_e.j);
        chk("data_out", longint'($signed(bus.data_out)), mon_e.data);
        chk("degenerate_out", longint'(bus.degenerate_out), mon_e.degen);
        chk("last_out", longint'(bus.last_out), mon_e.last);
      end
    end
  end

  task automatic do_start(input int i, input int jlo, input bit mode);
    @(posedge clk); #1;
    bus.start_valid_in = 1'b1;
    bus.i_in           = IW'(i);
    bus.j_lo_in        = IW'(jlo);
    bus.mode_in        = mode;
    @(posedge clk); #1;
    bus.start_valid_in = 1'b0;
  endtask

  task automatic wait_rd(output int c, output int a, output bit ok);
    ok = 1'b0; c = 0; a = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.t_rd_out) begin
        c = cyc; a = int'(bus.t_addr_out); ok = 1'b1;
        return;
      end
    end
    chk("rd_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.out_valid_out) begin
        c = cyc; ok = 1'b1;
        return;
      end
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.start_ready_out && sb.size() == 0) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic range_case(input int i, input int jlo, input string tag);
    int act;
    do_start(i, jlo, 1'b0);
    chk({tag, "_pulse"}, longint'(bus.range_err_out), 1);
    chk({tag, "_busy"}, longint'(bus.busy_out), 0);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, longint'(bus.range_err_out), 0);
    act = 0;
    repeat (ML + 60) begin
      @(negedge clk);
      if (bus.t_rd_out || bus.out_valid_out) act++;
    end
    chk({tag, "_no_activity"}, act, 0);
    chk({tag, "_ready"}, longint'(bus.start_ready_out), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_rd, c_v, c_prev, a;
    bit ok;
    logic signed [WIDTH-1:0] cap;

    bus.start_valid_in = 1'b0;
    bus.i_in           = '0;
    bus.j_lo_in        = '0;
    bus.mode_in        = 1'b0;
    bus.out_ready_in   = 1'b1;
    for (int k = 0; k < int'(I_MAX); k++) begin
      tab0[k] = '0; tab1[k] = '0; tab2[k] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_start_ready", longint'(bus.start_ready_out), 1);
    chk("rst_busy", longint'(bus.busy_out), 0);
    chk("rst_out_valid", longint'(bus.out_valid_out), 0);
    chk("rst_t_rd", longint'(bus.t_rd_out), 0);
    chk("rst_data", longint'($signed(bus.data_out)), 0);
    rst_n = 1'b1;

    // Two-coefficient fit, Ti = (3, 2, 1); j = 0 result is a known constant.
    for (int k = 0; k < 5; k++) begin
      tab0[k] = 32'(20000 * (k + 1));
      tab1[k] = 32'(15000 * (k + 1) - 40000);
      tab2[k] = 32'(7000 * (k + 2));
    end
    tab0[5] = 196608; tab1[5] = 131072; tab2[5] = 65536;
    push_exp(0, 104859, 0, 0);
    push_model(5, 1, 5, 1'b0);
    do_start(5, 0, 1'b0);
    chk("busy_after_start", longint'(bus.busy_out), 1);
    chk("ready_low_busy", longint'(bus.start_ready_out), 0);
    wait_idle("job1_timeout");

    // Zero denominator.
    tab0[0] = 131072; tab1[0] = 131072; tab2[0] = 65536;
    push_exp(0, 131072, 1, 1);
    do_start(0, 0, 1'b0);
    wait_idle("degen_timeout");

    // Single-coefficient fit.
    tab0[0] = 262144; tab1[0] = 131072; tab2[0] = 12345;
    push_exp(0, 196608, 0, 1);
    do_start(0, 0, 1'b1);
    wait_idle("mode1_timeout");

    // Address order, per-j latency and throughput.
    tab0[0] = 50000;  tab1[0] = -30000; tab2[0] = 9000;
    tab0[1] = 120000; tab1[1] = 40000;  tab2[1] = -25000;
    tab0[2] = 170000; tab1[2] = 95000;  tab2[2] = 30000;
    tab0[3] = 300000; tab1[3] = 180000; tab2[3] = 61000;
    push_model(3, 1, 3, 1'b0);
    do_start(3, 1, 1'b0);
    wait_rd(c_rd, a, ok);
    if (ok) chk("addr_ti", a, 3);
    c_prev = 0;
    for (int j = 1; j <= 3; j++) begin
      wait_rd(c_rd, a, ok);
      if (ok) chk("addr_tj", a, j - 1);
      if (j == 2) chk("result_period", c_rd - c_prev, ML + 52);
      c_prev = c_rd;
      wait_valid(c_v, ok);
      if (ok) chk("per_j_latency", c_v - c_rd, ML + 51);
    end
    wait_idle("seq_timeout");
    chk("seq_idle_busy", longint'(bus.busy_out), 0);

    // Back-pressure: result held, no further reads until the handshake.
    @(posedge clk); #1;
    bus.out_ready_in = 1'b0;
    push_model(2, 1, 2, 1'b0);
    do_start(2, 1, 1'b0);
    wait_valid(c_v, ok);
    cap = bus.data_out;
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", longint'(bus.out_valid_out), 1);
      chk("hold_data", longint'($signed(bus.data_out)), longint'(cap));
      chk("hold_no_rd", longint'(bus.t_rd_out), 0);
    end
    @(posedge clk); #1;
    bus.out_ready_in = 1'b1;
    wait_rd(c_rd, a, ok);
    if (ok) chk("rd_after_release", a, 1);
    wait_idle("bp_timeout");

    range_case(2, 4, "jlo_gt_i");
    range_case(200, 0, "i_too_big");

    // Reset in the middle of the divide.
    do_start(1, 0, 1'b0);
    repeat (2 * ML + 25) @(negedge clk);
    chk("busy_in_div", longint'(bus.busy_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", longint'(bus.busy_out), 0);
    chk("mrst_start_ready", longint'(bus.start_ready_out), 1);
    chk("mrst_t_rd", longint'(bus.t_rd_out), 0);
    chk("mrst_out_valid", longint'(bus.out_valid_out), 0);
    chk("mrst_data", longint'($signed(bus.data_out)), 0);
    chk("mrst_last", longint'(bus.last_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_model(3, 0, 3, 1'b1);
    do_start(3, 0, 1'b1);
    wait_idle("post_rst_timeout");

    // Random tables and jobs in both modes.
    for (int n = 0; n < 6; n++) begin
      int ri, rj;
      bit rm;
      for (int k = 0; k < 10; k++) begin
        tab0[k] = 32'(int'($urandom_range(0, 2097152)) - 1048576);
        tab1[k] = 32'(int'($urandom_range(0, 2097152)) - 1048576);
        tab2[k] = 32'(int'($urandom_range(0, 2097152)) - 1048576);
      end
      ri = int'($urandom_range(0, 9));
      rj = int'($urandom_range(0, ri));
      rm = 1'($urandom_range(0, 1));
      push_model(ri, rj, ri, rm);
      do_start(ri, rj, rm);
      wait_idle("rand_timeout");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/emin_engine.md
Name: emin_engine

Overview:
- Computes the minimum segment energy E_min(j, i) for every j in [j_lo, i] from a prefix-sum table T held in external BRAM. Each T entry has three channels (T0, T1, T2).
- Successor to the fixed 3-value E_min stage, with these additions:
  - fixed-point fraction parameter
  - configurable memory latency
  - an internal bit-serial signed divider
  - start and output ready/valid handshakes
  - selectable one- or two-coefficient fit mode
  - degenerate-denominator handling and saturation
- Sits between the T BRAM and the E_min buffer writer in the segmentation datapath.

Parameters:
- WIDTH, 32, signed data width of T and of all results.
- FRAC, 16, fraction bits (Q format) for all fixed-point values; FRAC < WIDTH.
- I_MAX, 160, number of T entries; index width is IW = $clog2(I_MAX).
- MEM_LATENCY, 2, cycles from t_rd_out to valid t_data_in (≥1).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- start_valid_in  in  1  job request.
- start_ready_out  out  1  high in IDLE only.
- i_in  in  IW  segment end index i.
- j_lo_in  in  IW  first j to compute.
- mode_in  in  1  0 = two-coefficient fit, 1 = single-coefficient fit.
- t_rd_out  out  1  T read strobe, one cycle.
- t_addr_out  out  IW  T read address.
- t_data_in  in  3×WIDTH  {T0, T1, T2}, signed, valid MEM_LATENCY cycles after the strobe.
- out_valid_out  out  1  result valid.
- out_ready_in  in  1  downstream accepts result.
- j_out  out  IW  j of the current result.
- data_out  out  WIDTH  signed E_min(j, i), Q FRAC.
- degenerate_out  out  1  denominator was zero for this result.
- last_out  out  1  result is for j == i.
- range_err_out  out  1  one-cycle pulse: job rejected.
- busy_out  out  1  high when not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n_in low):
  - state=IDLE; all outputs 0 except start_ready_out=1; in-flight job discarded.
  - Deassertion takes effect at the next edge.
- States: IDLE, FETCH_I, FETCH_J, RDIFF, PROD, DIV, COMB, OUT.
- IDLE:
  - On start_valid_in & start_ready_out, capture i, j_lo, mode.
  - If i_in ≥ I_MAX or j_lo_in > i_in: pulse range_err_out, stay IDLE.
  - Otherwise: t_rd_out=1, t_addr_out=i, go to FETCH_I.
- FETCH_I: wait MEM_LATENCY cycles, latch Ti = t_data_in, set j = j_lo, go to FETCH_J.
- FETCH_J:
  - If j > 0: issue a read of j−1 on entry.
  - If j == 0: issue no read and use Tj = 0.
  - Wait MEM_LATENCY cycles either way, so timing is identical.
- RDIFF (1 cycle): rk = Ti[k] − Tj[k], WIDTH-bit wrap.
- PROD (1 cycle). Let m(a, b) = (a·b) >>> FRAC on the full 2·WIDTH product, saturated to WIDTH.
  - mode 0: an = m(r0, r1) − m(r1, r2); bn = m(r0, r2) − m(r1, r1); d = m(r0, r0) − m(r1, r1).
  - mode 1: an = r1; bn = 0; d = r0.
  - All subtractions are saturating.
- DIV (WIDTH+FRAC cycles, fixed regardless of operands):
  - Two restoring dividers run in parallel on magnitudes: alpha = (an << FRAC)/d and beta = (bn << FRAC)/d.
  - Quotients truncate toward zero; sign = sign(num) XOR sign(d); results saturate to WIDTH.
  - If d == 0: alpha = beta = 0 and the degenerate flag is set.
- COMB (1 cycle): E = r0 − m(r1, alpha) − m(r2, beta), saturating.
- OUT:
  - Drive out_valid_out=1 with j_out, data_out, degenerate_out, and last_out = (j == i).
  - Hold all values stable until out_ready_in.
  - On handshake: if last, go to IDLE; else j++ and go to FETCH_J.
- Per-j latency, from entering FETCH_J to out_valid_out: MEM_LATENCY + WIDTH + FRAC + 3 cycles. Throughput is one result per MEM_LATENCY + WIDTH + FRAC + 4 cycles with out_ready_in held high.
- start_valid_in while busy is ignored, since start_ready_out=0.

Test Plan:
- FRAC=16, mode 0, Ti=(3.0, 2.0, 1.0) = (196608, 131072, 65536), i=5, j_lo=0:
  - j=0 output: alpha=52428, beta=−13107.
  - data_out=104859, degenerate_out=0, output exactly MEM_LATENCY+51 cycles after FETCH_J entry.
- mode 0, Ti=(2.0, 2.0, 1.0), j=0 → d=0, degenerate_out=1, data_out=131072.
- mode 1, Ti=(4.0, 2.0, any), j=0 → alpha=32768, data_out=196608.
- i=3, j_lo=1, T table with distinct entries:
  - t_addr_out sequence is 3, 0, 1, 2.
  - Outputs are j=1, 2, 3, with last_out only on j=3; then IDLE and start_ready_out=1.
- Hold out_ready_in low for 10 cycles during OUT:
  - out_valid_out and data_out stay stable.
  - No t_rd_out is issued until the handshake.
- Edge cases:
  - j_lo=4, i=2 → range_err_out 1-cycle pulse, no outputs.
  - i=200 with I_MAX=160 → same response.
  - rst_n_in low mid-DIV → all outputs 0 immediately; next job runs normally.
